// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared helpers for the synchronous and dual-clock FIFOs.
//   ptr_width : address width for a given depth (clog2)
//   ptr_empty : pointers equal, including the wrap bit
//   ptr_full  : wrap bits differ, address bits equal
// Pointers are passed zero-extended to 32 bits along with the address
// width, so one set of helpers serves every depth.
package fifo_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic ptr_empty(input logic [31:0] wp,
                                       input logic [31:0] rp,
                                       input int          pw);
        logic [31:0] mask;
        mask = (32'd1 << (pw + 1)) - 32'd1;
        return (wp & mask) == (rp & mask);
    endfunction

    function automatic logic ptr_full(input logic [31:0] wp,
                                      input logic [31:0] rp,
                                      input int          pw);
        logic [31:0] mask;
        mask = (32'd1 << pw) - 32'd1;
        return ((((wp ^ rp) >> pw) & 32'd1) == 32'd1) && ((wp & mask) == (rp & mask));
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
// WIDTH x DEPTH storage with a synchronous write port and an
// asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and a selectable first-word-fall-through read mode.
//   clk          : clock, rising edge
//   res          : asynchronous active-high reset
//   wr_en/wdata  : write request and data
//   rd_en        : read request (pop of the head word in FWFT mode)
//   rdata        : read data
//   full/empty   : occupancy == FIFO_SIZE / == 0
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : occupancy 0..FIFO_SIZE
//   overflow     : one-cycle pulse after a rejected write
//   underflow    : one-cycle pulse after a rejected read
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FIFO_SIZE = 16,
    parameter int PTR_WIDTH = ptr_width(FIFO_SIZE),
    parameter int AF_LEVEL  = FIFO_SIZE - 2,
    parameter int AE_LEVEL  = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [PTR_WIDTH:0] AF_CNT = (PTR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] AE_CNT = (PTR_WIDTH + 1)'(AE_LEVEL);

    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic [PTR_WIDTH:0] wr_ptr_nxt;
    logic [PTR_WIDTH:0] rd_ptr_nxt;
    logic [PTR_WIDTH:0] count_nxt;
    logic               wr_acc;
    logic               rd_acc;
    logic [WIDTH-1:0]   mem_rdata;

    // Gating uses the registered flags only: a simultaneous read does not
    // make room for a write when full, nor does a write feed a read when empty.
    assign wr_acc     = wr_en && !full;
    assign rd_acc     = rd_en && !empty;
    assign wr_ptr_nxt = wr_ptr + {{PTR_WIDTH{1'b0}}, wr_acc};
    assign rd_ptr_nxt = rd_ptr + {{PTR_WIDTH{1'b0}}, rd_acc};
    assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            // All status flags come from next-state pointers so they line up
            // with count on the same edge.
            full         <= ptr_full(32'(wr_ptr_nxt), 32'(rd_ptr_nxt), PTR_WIDTH);
            empty        <= ptr_empty(32'(wr_ptr_nxt), 32'(rd_ptr_nxt), PTR_WIDTH);
            almost_full  <= (count_nxt >= AF_CNT);
            almost_empty <= (count_nxt <= AE_CNT);
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_SIZE),
        .AW    (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[PTR_WIDTH-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[PTR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT) begin : g_fwft
            // Head word shown directly; forced to zero so stale memory
            // never leaks out while the FIFO is empty.
            assign rdata = empty ? '0 : mem_rdata;
        end else begin : g_reg
            logic [WIDTH-1:0] rdata_q;

            always_ff @(posedge clk or posedge res) begin
                if (res) begin
                    rdata_q <= '0;
                end else if (rd_acc) begin
                    rdata_q <= mem_rdata;
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       res;

    logic       wr_en0, rd_en0;
    logic [7:0] wdata0, rdata0;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic [4:0] count0;

    logic       wr_en1, rd_en1;
    logic [7:0] wdata1, rdata1;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] count1;

    int         total = 0;
    int         bad   = 0;

    int         m_cnt = 0;
    logic [7:0] last_rd = 8'h00;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .FIFO_SIZE(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
        .clk(clk), .res(res), .wr_en(wr_en0), .wdata(wdata0), .rd_en(rd_en0),
        .rdata(rdata0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(.WIDTH(8), .FIFO_SIZE(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) dut1 (
        .clk(clk), .res(res), .wr_en(wr_en1), .wdata(wdata1), .rd_en(rd_en1),
        .rdata(rdata1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check0(input logic exp_ovf, input logic exp_unf, input logic [7:0] exp_rd);
        chk("d0_count", 32'(count0), 32'(m_cnt));
        chk("d0_full",  32'(full0),  32'(m_cnt == 16));
        chk("d0_empty", 32'(empty0), 32'(m_cnt == 0));
        chk("d0_af",    32'(af0),    32'(m_cnt >= 14));
        chk("d0_ae",    32'(ae0),    32'(m_cnt <= 2));
        chk("d0_ovf",   32'(ovf0),   32'(exp_ovf));
        chk("d0_unf",   32'(unf0),   32'(exp_unf));
        chk("d0_rdata", 32'(rdata0), 32'(exp_rd));
    endtask

    // One clock of stimulus on the registered-read FIFO, checked against the model.
    task automatic cyc0(input logic we, input logic [7:0] wd, input logic re);
        logic       wacc, racc, e_ovf, e_unf;
        logic [7:0] exp_rd;
        wacc   = we && (m_cnt != 16);
        racc   = re && (m_cnt != 0);
        e_ovf  = we && (m_cnt == 16);
        e_unf  = re && (m_cnt == 0);
        exp_rd = last_rd;
        if (racc) exp_rd = sb.pop_front();
        if (wacc) sb.push_back(wd);
        m_cnt  = m_cnt + int'(wacc) - int'(racc);
        wr_en0 = we;
        wdata0 = wd;
        rd_en0 = re;
        tick();
        wr_en0 = 1'b0;
        rd_en0 = 1'b0;
        last_rd = exp_rd;
        check0(e_ovf, e_unf, exp_rd);
    endtask

    task automatic check_reset_state();
        chk("rst_d0_count", 32'(count0), 32'd0);
        chk("rst_d0_empty", 32'(empty0), 32'd1);
        chk("rst_d0_full",  32'(full0),  32'd0);
        chk("rst_d0_ae",    32'(ae0),    32'd1);
        chk("rst_d0_af",    32'(af0),    32'd0);
        chk("rst_d0_ovf",   32'(ovf0),   32'd0);
        chk("rst_d0_unf",   32'(unf0),   32'd0);
        chk("rst_d0_rdata", 32'(rdata0), 32'd0);
        chk("rst_d1_count", 32'(count1), 32'd0);
        chk("rst_d1_empty", 32'(empty1), 32'd1);
        chk("rst_d1_rdata", 32'(rdata1), 32'd0);
    endtask

    initial begin
        res    = 1'b1;
        wr_en0 = 1'b0; rd_en0 = 1'b0; wdata0 = 8'h00;
        wr_en1 = 1'b0; rd_en1 = 1'b0; wdata1 = 8'h00;
        repeat (2) tick();
        check_reset_state();
        res = 1'b0;
        tick();

        // Fill with 0x01..0x10, then a 17th write must be rejected.
        for (int i = 1; i <= 16; i++) cyc0(1'b1, 8'(i), 1'b0);
        cyc0(1'b1, 8'h11, 1'b0);
        cyc0(1'b0, 8'h00, 1'b0);
        // Drain; 0x11 must never appear.
        for (int i = 0; i < 16; i++) cyc0(1'b0, 8'h00, 1'b1);
        // Underflow on empty: rdata holds 0x10.
        cyc0(1'b0, 8'h00, 1'b1);
        cyc0(1'b0, 8'h00, 1'b0);

        // Steady state at count=5 with simultaneous read and write.
        for (int i = 0; i < 5; i++) cyc0(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 40; i++) cyc0(1'b1, 8'(8'h80 + i), 1'b1);
        for (int i = 0; i < 5; i++) cyc0(1'b0, 8'h00, 1'b1);

        // Full with read+write together: read wins, write rejected.
        for (int i = 0; i < 16; i++) cyc0(1'b1, 8'(8'hC0 + i), 1'b0);
        cyc0(1'b1, 8'hEE, 1'b1);
        for (int i = 0; i < 15; i++) cyc0(1'b0, 8'h00, 1'b1);

        // FWFT: head word visible before any rd_en, pop empties and zeroes rdata.
        wr_en1 = 1'b1; wdata1 = 8'hA5;
        tick();
        wr_en1 = 1'b0;
        chk("fwft_rdata", 32'(rdata1), 32'hA5);
        chk("fwft_empty", 32'(empty1), 32'd0);
        chk("fwft_count", 32'(count1), 32'd1);
        rd_en1 = 1'b1;
        tick();
        rd_en1 = 1'b0;
        chk("fwft_pop_empty", 32'(empty1), 32'd1);
        chk("fwft_pop_rdata", 32'(rdata1), 32'd0);
        chk("fwft_pop_unf",   32'(unf1),   32'd0);

        // Asynchronous reset pulse at count=9, checked before the next edge.
        for (int i = 0; i < 9; i++) cyc0(1'b1, 8'(8'h20 + i), 1'b0);
        #2;
        res = 1'b1;
        #1;
        check_reset_state();
        m_cnt = 0;
        sb.delete();
        last_rd = 8'h00;
        tick();
        res = 1'b0;
        cyc0(1'b1, 8'h3C, 1'b0);
        cyc0(1'b0, 8'h00, 1'b1);
        chk("post_rst_rdata", 32'(rdata0), 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
